mem_bus_arbiter: RTL and testbench

Arbitrates the single system-bus master port between the three memory-side requestors of the core pipeline: 0 = page-table walker, 1 = load/instruction data, 2 = store data. It sits directly downstream of the fetch/memory stages and upstream of the `bus_reqcyc`/`bus_resp` pins. It grants one requestor at a time and uses round-robin priority. It holds the grant for the whole bus transaction and revokes stale grants with a watchdog.

---
 rtl/bus_pkg.sv | 21 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the memory-side bus arbitration logic.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: arbiter FSM state encoding and the fixed requestor indices of the
// core pipeline's memory-side requestors.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Requestor slots on the bus_reqcyc / bus_grant vectors.
  localparam int REQ_VA_PA      = 0;  // page-table walker
  localparam int REQ_ADDR_DATA  = 1;  // load / instruction data
  localparam int REQ_STORE_DATA = 2;  // store data

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first set request at or after 'start', wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; vld low when no request bit is set.
//
// Ports:
//   req   [N-1:0]  request vector
//   start [IW-1:0] index searched first (must be < N)
//   idx   [IW-1:0] winning index (0 when vld is low)
//   vld            any request present
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          vld
);

  // One extra bit so start + offset never overflows before the wrap.
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  always_comb begin
    idx  = '0;
    vld  = 1'b0;
    sum  = '0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, start} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      cand = sum[IW-1:0];
      if (!vld && req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin owner arbiter for the single system-bus master port.
// Latency: request sampled in IDLE -> registered one-hot grant after that edge.
// Backpressure: losers hold bus_reqcyc; grant held through bus_busy, watchdog revokes idle grants.
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   bus_reqcyc [NREQ-1:0] level requests, held until granted or abandoned
//   bus_grant  [NREQ-1:0] registered one-hot (or zero) grant
//   bus_busy              owner is running a bus transaction
//   out_owner             index of the current / most recent grantee
//   out_owner_valid       high whenever bus_grant is nonzero
//   out_timeout           one-cycle pulse when the watchdog revokes a grant
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int NREQ          = 3,
  parameter int GRANT_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         bus_reqcyc,
  output logic [NREQ-1:0]         bus_grant,
  input  logic                    bus_busy,
  output logic [$clog2(NREQ)-1:0] out_owner,
  output logic                    out_owner_valid,
  output logic                    out_timeout
);

  localparam int IW = $clog2(NREQ);
  localparam int WW = $clog2(GRANT_TIMEOUT);

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;
  logic [IW-1:0]   last_owner_q, last_owner_d;
  logic [WW-1:0]   wdog_q, wdog_d;

  logic [IW-1:0]   rr_start;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;

  // Search begins one past the previous owner so every requestor gets a turn.
  assign rr_start = (last_owner_q == IW'(NREQ-1)) ? '0 : last_owner_q + IW'(1);

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_pick (
    .req   (bus_reqcyc),
    .start (rr_start),
    .idx   (pick_idx),
    .vld   (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      valid_q      <= 1'b0;
      timeout_q    <= 1'b0;
      last_owner_q <= IW'(NREQ-1);
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      valid_q      <= valid_d;
      timeout_q    <= timeout_d;
      last_owner_q <= last_owner_d;
      wdog_q       <= wdog_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    valid_d      = valid_q;
    timeout_d    = 1'b0;
    last_owner_d = last_owner_q;
    wdog_d       = wdog_q;

    unique case (state_q)
      IDLE: begin
        // bus_busy is deliberately not looked at here: a stray busy with no
        // owner is a protocol error and must not disturb arbitration.
        if (pick_vld) begin
          state_d = GRANT;
          grant_d = NREQ'(1) << pick_idx;
          owner_d = pick_idx;
          valid_d = 1'b1;
          wdog_d  = '0;
        end else begin
          grant_d = '0;
          valid_d = 1'b0;
        end
      end

      GRANT: begin
        // Busy outranks an abandon seen in the same cycle: the owner has
        // already started driving the bus.
        if (bus_busy) begin
          state_d = BUSY;
        end else if (!bus_reqcyc[owner_q]) begin
          state_d = RELEASE;
          grant_d = '0;
          valid_d = 1'b0;
        end else if (wdog_q == WW'(GRANT_TIMEOUT-1)) begin
          state_d   = RELEASE;
          grant_d   = '0;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
        end else if (wdog_q != {WW{1'b1}}) begin
          wdog_d = wdog_q + WW'(1);
        end
      end

      BUSY: begin
        // Ownership is kept for the whole transaction; no watchdog here.
        if (!bus_busy) begin
          state_d = RELEASE;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end

      RELEASE: begin
        state_d      = IDLE;
        grant_d      = '0;
        valid_d      = 1'b0;
        last_owner_d = owner_q;
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus_grant       = grant_q;
  assign out_owner       = owner_q;
  assign out_owner_valid = valid_q;
  assign out_timeout     = timeout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (NREQ=3, GRANT_TIMEOUT=16).
// Each step queues the outputs expected after the next clock edge, then
// pops and compares them 1 time unit after that edge.
module tb_mem_bus_arbiter;
  import bus_pkg::*;

  typedef struct packed {
    logic [2:0] grant;
    logic [1:0] owner;
    logic       valid;
    logic       timeout;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] bus_reqcyc;
  logic [2:0] bus_grant;
  logic       bus_busy;
  logic [1:0] out_owner;
  logic       out_owner_valid;
  logic       out_timeout;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    fails  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .NREQ          (3),
    .GRANT_TIMEOUT (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .bus_reqcyc      (bus_reqcyc),
    .bus_grant       (bus_grant),
    .bus_busy        (bus_busy),
    .out_owner       (out_owner),
    .out_owner_valid (out_owner_valid),
    .out_timeout     (out_timeout)
  );

  function automatic logic [2:0] oh(input int i);
    logic [2:0] one;
    one = 3'b001;
    return one << i;
  endfunction

  // Queue the expectation for the current inputs, clock once, then compare.
  task automatic step(input string tag, input logic [2:0] g, input int o,
                      input logic v, input logic to);
    exp_t  e;
    exp_t  obs;
    string t;
    e.grant   = g;
    e.owner   = 2'(o);
    e.valid   = v;
    e.timeout = to;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    obs = {bus_grant, out_owner, out_owner_valid, out_timeout};
    checks++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s: observed grant=%b owner=%0d valid=%b timeout=%b, expected grant=%b owner=%0d valid=%b timeout=%b",
             t, obs.grant, obs.owner, obs.valid, obs.timeout,
             e.grant, e.owner, e.valid, e.timeout);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int order[4];
    order = '{REQ_VA_PA, REQ_ADDR_DATA, REQ_STORE_DATA, REQ_VA_PA};

    reset      = 1'b1;
    bus_reqcyc = 3'b000;
    bus_busy   = 1'b0;
    step("reset_a", 3'b000, 0, 1'b0, 1'b0);
    step("reset_b", 3'b000, 0, 1'b0, 1'b0);

    // Single requestor, 5-cycle busy transaction; request dropped mid-busy.
    reset      = 1'b0;
    bus_reqcyc = oh(REQ_ADDR_DATA);
    step("single_grant", oh(REQ_ADDR_DATA), REQ_ADDR_DATA, 1'b1, 1'b0);
    bus_busy = 1'b1;
    step("single_busy", oh(REQ_ADDR_DATA), REQ_ADDR_DATA, 1'b1, 1'b0);
    bus_reqcyc = 3'b000;
    for (int i = 0; i < 4; i++)
      step("single_hold", oh(REQ_ADDR_DATA), REQ_ADDR_DATA, 1'b1, 1'b0);
    bus_busy = 1'b0;
    step("single_release", 3'b000, REQ_ADDR_DATA, 1'b0, 1'b0);
    step("single_idle", 3'b000, REQ_ADDR_DATA, 1'b0, 1'b0);

    // Stray busy with nobody granted leaves the arbiter idle.
    bus_busy = 1'b1;
    step("idle_busy_a", 3'b000, REQ_ADDR_DATA, 1'b0, 1'b0);
    step("idle_busy_b", 3'b000, REQ_ADDR_DATA, 1'b0, 1'b0);
    bus_busy = 1'b0;

    // Contention after reset: 0,1,2,0 with 3-cycle transactions.
    reset = 1'b1;
    step("reset_again", 3'b000, 0, 1'b0, 1'b0);
    reset      = 1'b0;
    bus_reqcyc = 3'b111;
    for (int k = 0; k < 4; k++) begin
      bus_busy = 1'b0;
      step("rr_grant", oh(order[k]), order[k], 1'b1, 1'b0);
      bus_busy = 1'b1;
      for (int j = 0; j < 3; j++)
        step("rr_busy", oh(order[k]), order[k], 1'b1, 1'b0);
      bus_busy = 1'b0;
      step("rr_release", 3'b000, order[k], 1'b0, 1'b0);
      step("rr_gap", 3'b000, order[k], 1'b0, 1'b0);
    end
    bus_reqcyc = 3'b000;

    // Abandon: last owner 0, so 2 beats 0; dropping req 2 releases, 0 is next.
    bus_reqcyc = oh(REQ_STORE_DATA) | oh(REQ_VA_PA);
    step("abandon_grant", oh(REQ_STORE_DATA), REQ_STORE_DATA, 1'b1, 1'b0);
    bus_reqcyc = oh(REQ_VA_PA);
    step("abandon_release", 3'b000, REQ_STORE_DATA, 1'b0, 1'b0);
    step("abandon_idle", 3'b000, REQ_STORE_DATA, 1'b0, 1'b0);
    step("abandon_next", oh(REQ_VA_PA), REQ_VA_PA, 1'b1, 1'b0);
    bus_reqcyc = 3'b000;
    step("abandon2_release", 3'b000, REQ_VA_PA, 1'b0, 1'b0);
    step("abandon2_idle", 3'b000, REQ_VA_PA, 1'b0, 1'b0);

    // Watchdog: grant high exactly 16 cycles, then one timeout pulse.
    bus_reqcyc = oh(REQ_ADDR_DATA);
    step("wd_grant", oh(REQ_ADDR_DATA), REQ_ADDR_DATA, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++)
      step("wd_hold", oh(REQ_ADDR_DATA), REQ_ADDR_DATA, 1'b1, 1'b0);
    step("wd_timeout", 3'b000, REQ_ADDR_DATA, 1'b0, 1'b1);
    bus_reqcyc = 3'b000;
    step("wd_pulse_end", 3'b000, REQ_ADDR_DATA, 1'b0, 1'b0);
    step("wd_idle", 3'b000, REQ_ADDR_DATA, 1'b0, 1'b0);

    // Busy rise and request drop together in GRANT: busy wins.
    bus_reqcyc = oh(REQ_VA_PA);
    step("sim_grant", oh(REQ_VA_PA), REQ_VA_PA, 1'b1, 1'b0);
    bus_reqcyc = 3'b000;
    bus_busy   = 1'b1;
    step("sim_busy", oh(REQ_VA_PA), REQ_VA_PA, 1'b1, 1'b0);
    step("sim_hold", oh(REQ_VA_PA), REQ_VA_PA, 1'b1, 1'b0);
    bus_busy = 1'b0;
    step("sim_release", 3'b000, REQ_VA_PA, 1'b0, 1'b0);
    step("sim_idle", 3'b000, REQ_VA_PA, 1'b0, 1'b0);

    // Reset during BUSY discards ownership; requestor 0 wins afterwards.
    bus_reqcyc = 3'b111;
    step("rb_grant", oh(REQ_ADDR_DATA), REQ_ADDR_DATA, 1'b1, 1'b0);
    bus_busy = 1'b1;
    step("rb_busy", oh(REQ_ADDR_DATA), REQ_ADDR_DATA, 1'b1, 1'b0);
    reset = 1'b1;
    step("rb_reset", 3'b000, 0, 1'b0, 1'b0);
    reset    = 1'b0;
    bus_busy = 1'b0;
    step("rb_win0", oh(REQ_VA_PA), REQ_VA_PA, 1'b1, 1'b0);
    bus_reqcyc = 3'b000;
    step("rb_release", 3'b000, REQ_VA_PA, 1'b0, 1'b0);
    step("rb_idle", 3'b000, REQ_VA_PA, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
